dcache_direct: RTL

Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's memory stage and the backing data memory. It holds hits on the memory-stage read path to zero added latency. It converts misses and all stores into handshaked transactions on the backing-memory port, and raises a stall to freeze the pipeline meanwhile. One 32-bit word per line.

---
 rtl/dcache_direct.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache, one 32-bit word
// per line. Load hits return data combinationally with no stall; load misses
// and all stores become a single handshaked backing-memory transaction while
// the pipeline is stalled.
// Optional feature: define DCACHE_STATS_EN to add hit_count/miss_count ports.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | accepting accesses; load hits served here with no stall
// RD_MISS | line fill in flight; completes when mem_ready is high
// WR_THRU | store write-through in flight; merges into line on a hit
module dcache_direct #(
    parameter int SETS  = 64,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} stateT;

    stateT state, nextState;

    logic [SETS-1:0]  validBits;
    logic [TAG_W-1:0] tagArr  [SETS];
    logic [31:0]      dataArr [SETS];

    logic [29:0] pendWord;
    logic [3:0]  pendBe;
    logic [31:0] pendData;

    logic [IDX_W-1:0] reqIdx, pendIdx;
    logic [TAG_W-1:0] reqTag, pendTag;
    logic             reqHit, pendHit;
    logic             captureReq, fillLine, mergeLine;
    logic [1:0]       unusedAddrBits;
`ifdef DCACHE_STATS_EN
    logic             countHit, countMiss;
`endif

    assign unusedAddrBits = cpu_addr[1:0];

    assign reqIdx  = cpu_addr[IDX_W+1:2];
    assign reqTag  = cpu_addr[31:IDX_W+2];
    assign pendIdx = pendWord[IDX_W-1:0];
    assign pendTag = pendWord[29:IDX_W];
    assign reqHit  = validBits[reqIdx] && (tagArr[reqIdx] == reqTag);
    // Store completion rechecks the array rather than trusting the IDLE lookup.
    assign pendHit = validBits[pendIdx] && (tagArr[pendIdx] == pendTag);

    // Request fields come from the latch so they stay stable while waiting.
    assign mem_addr  = {pendWord, 2'b00};
    assign mem_be    = pendBe;
    assign mem_wdata = pendData;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state decode plus stall, read data and memory request outputs.
    always_comb begin
        nextState  = state;
        stall      = 1'b0;
        cpu_rdata  = 32'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        captureReq = 1'b0;
        fillLine   = 1'b0;
        mergeLine  = 1'b0;
`ifdef DCACHE_STATS_EN
        countHit   = 1'b0;
        countMiss  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        stall      = 1'b1;
                        captureReq = 1'b1;
                        nextState  = WR_THRU;
                    end else if (reqHit) begin
                        cpu_rdata = dataArr[reqIdx];
`ifdef DCACHE_STATS_EN
                        countHit  = 1'b1;
`endif
                    end else begin
                        stall      = 1'b1;
                        captureReq = 1'b1;
                        nextState  = RD_MISS;
`ifdef DCACHE_STATS_EN
                        countMiss  = 1'b1;
`endif
                    end
                end
            end
            RD_MISS: begin
                mem_req = 1'b1;
                stall   = ~mem_ready;
                if (mem_ready) begin
                    cpu_rdata = mem_rdata;
                    fillLine  = 1'b1;
                    nextState = IDLE;
                end
            end
            WR_THRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall   = ~mem_ready;
                if (mem_ready) begin
                    mergeLine = pendHit;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Latch the access when it leaves IDLE; the pipeline holds its inputs anyway.
    always_ff @(posedge clk) begin
        if (captureReq) begin
            pendWord <= cpu_addr[31:2];
            pendBe   <= cpu_be;
            pendData <= cpu_wdata;
        end
    end

    // Valid bits are the only array state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst)           validBits          <= '0;
        else if (fillLine) validBits[pendIdx] <= 1'b1;
    end

    // Tag/data arrays: fill overwrites unconditionally, store hits merge bytes.
    always_ff @(posedge clk) begin
        if (!rst && fillLine) begin
            tagArr[pendIdx]  <= pendTag;
            dataArr[pendIdx] <= mem_rdata;
        end else if (!rst && mergeLine) begin
            for (int b = 0; b < 4; b++) begin
                if (pendBe[b]) dataArr[pendIdx][8*b +: 8] <= pendData[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss statistics, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (countHit)  hit_count  <= hit_count + 32'd1;
            if (countMiss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
